render_sched: RTL and testbench
===============================

RENDER_SCHED -- requirements
Module: render_sched

Interface
REQ-001 Parameter HSWAP, default 1280: hcount value at which the buffer swap is evaluated.
REQ-002 Parameter VACTIVE, default 480: number of visible lines.
REQ-003 Parameter VTOTAL, default 525: total lines per frame.
REQ-004 clk  in  1  50 MHz system clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hcount  in  11  horizontal counter (0..1599) from the VGA counters.
REQ-007 vcount  in  10  vertical counter (0..VTOTAL-1) from the VGA counters.
REQ-008 enable  in  1  when 1, new scanline renders may start.
REQ-009 tile_done  in  1  tile engine idle/complete level.
REQ-010 sprite_done  in  1  sprite engine idle/complete level.
REQ-011 clr_status  in  1  one-cycle pulse that clears the sticky flags.
REQ-012 tile_start  out  1  one-cycle start pulse to the tile engine.
REQ-013 sprite_start  out  1  one-cycle start pulse to the sprite engine.
REQ-014 render_line  out  10  line being rendered, held for the whole render.
REQ-015 buf_sel  out  1  linebuffer draw/display select; it toggles on swap.
REQ-016 line_abort  out  1  one-cycle pulse when a render misses its deadline.
REQ-017 vblank_irq  out  1  sticky level, set at vblank start.
REQ-018 overrun_flag  out  1  sticky level, set on any line_abort.
REQ-019 overrun_cnt  out  8  count of aborted lines, saturating.
REQ-020 frame_cnt  out  16  frame counter, wrapping.
REQ-021 busy  out  1  1 whenever the state is not IDLE.

Function
REQ-022 The block SHALL use the states IDLE, TILE, SPRITE and DONE.
REQ-023 A line-start event SHALL be defined as: hcount==0, enable==1, state==IDLE, and (vcount<=VACTIVE-2 or vcount==VTOTAL-1).
REQ-024 On a line-start event, tile_start SHALL be 1 on the next cycle only, state SHALL become TILE, and render_line SHALL be set to (vcount==VTOTAL-1 ? 0 : vcount+1).
REQ-025 In TILE and SPRITE, the done input SHALL be ignored for the first cycle after entry (guard cycle), so that a stale done level is not accepted.
REQ-026 TILE with tile_done==1 after the guard cycle SHALL pulse sprite_start for one cycle and move to SPRITE.
REQ-027 SPRITE with sprite_done==1 after the guard cycle SHALL move to DONE.
REQ-028 At hcount==HSWAP in DONE, buf_sel SHALL toggle and the state SHALL become IDLE in the same cycle.
REQ-029 At hcount==HSWAP in TILE or SPRITE, the block SHALL pulse line_abort, set overrun_flag, increment overrun_cnt (saturating at 255), leave buf_sel unchanged, and go to IDLE.
REQ-030 At hcount==HSWAP in IDLE, no action SHALL be taken.
REQ-031 enable falling mid-render SHALL NOT abort the render; the line SHALL complete and swap normally.
REQ-032 At hcount==0 with vcount==VACTIVE, frame_cnt SHALL increment (wrapping 65535->0) and vblank_irq SHALL be set.
REQ-033 clr_status SHALL clear vblank_irq and overrun_flag; overrun_cnt SHALL NOT be cleared.
REQ-034 If a set event and clr_status occur in the same cycle, the set SHALL win.
REQ-035 tile_start and sprite_start SHALL never both be 1 in the same cycle.
REQ-036 tile_start and sprite_start SHALL each be registered outputs with no combinational path from the inputs.

Reset
REQ-037 While reset==1: state SHALL be IDLE and every output SHALL be 0, including buf_sel, render_line and the counters.
REQ-038 Reset asserted mid-render SHALL drop any pending start and SHALL NOT pulse line_abort.

Structure
REQ-039 The state enum and the default timing constants (HSWAP, VACTIVE, VTOTAL) SHALL live in a shared package, vga_pkg.
REQ-040 The block SHALL be a single module with no sub-modules.

Verification
REQ-041 vcount=10, hcount 0->1599, tile_done drops then rises at hc=200, sprite_done at hc=900 -> tile_start at hc=1, sprite_start one cycle after tile_done is seen, buf_sel toggles at hc=1280, render_line=11.
REQ-042 vcount=524 -> render_line=0 and a full render occurs; vcount=479 and vcount=500 -> no tile_start.
REQ-043 sprite_done held 0 past hc=1280 -> line_abort pulses once, overrun_cnt=1, overrun_flag=1, buf_sel unchanged, busy=0.
REQ-044 256 consecutive aborted lines -> overrun_cnt=255; then clr_status -> overrun_flag=0 and overrun_cnt=255.
REQ-045 Done inputs held at 1 throughout -> sprite_start lands exactly 2 cycles after tile_start (guard cycle honoured); frame_cnt increments once per 525 lines; clr_status coinciding with vblank start -> vblank_irq=1.
REQ-046 Reset asserted at hc=500 in SPRITE -> next cycle all outputs 0, state IDLE, and the next line starts normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the scanline render scheduler state encoding.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TILE   = 2'd1,
        SPRITE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int HSWAP_DEF   = 1280;
    localparam int VACTIVE_DEF = 480;
    localparam int VTOTAL_DEF  = 525;

    localparam int HC_W = 11;
    localparam int VC_W = 10;

endpackage

// File: rtl/render_sched_if.sv
// Scheduler <-> render engine link: start pulses, done levels, line number and buffer select.
interface render_sched_if;

    logic                     tile_start;
    logic                     sprite_start;
    logic                     tile_done;
    logic                     sprite_done;
    logic [vga_pkg::VC_W-1:0] render_line;
    logic                     buf_sel;

    modport master (
        output tile_start, sprite_start, render_line, buf_sel,
        input  tile_done, sprite_done
    );

    modport slave (
        input  tile_start, sprite_start, render_line, buf_sel,
        output tile_done, sprite_done
    );

endinterface

// File: rtl/render_sched.sv
// Per-scanline render scheduler: starts tile then sprite engines one line ahead,
// swaps linebuffers at HSWAP, and aborts renders that miss that deadline.
module render_sched
    import vga_pkg::*;
#(
    parameter int HSWAP   = HSWAP_DEF,
    parameter int VACTIVE = VACTIVE_DEF,
    parameter int VTOTAL  = VTOTAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [HC_W-1:0]  hcount,
    input  logic [VC_W-1:0]  vcount,
    input  logic             enable,
    input  logic             clr_status,
    render_sched_if.master   eng,
    output logic             line_abort,
    output logic             vblank_irq,
    output logic             overrun_flag,
    output logic [7:0]       overrun_cnt,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    state_t            state_reg, state_next;
    logic              guard_reg, guard_next;
    logic              tile_start_reg, tile_start_next;
    logic              sprite_start_reg, sprite_start_next;
    logic [VC_W-1:0]   render_line_reg, render_line_next;
    logic              buf_sel_reg, buf_sel_next;
    logic              abort_reg, abort_next;
    logic [7:0]        overrun_cnt_reg, overrun_cnt_next;
    logic              overrun_flag_reg, overrun_flag_next;
    logic              vblank_reg, vblank_next;
    logic [15:0]       frame_cnt_reg, frame_cnt_next;

    logic at_swap;
    logic last_line;
    logic line_start;
    logic frame_tick;
    logic engine_done;

    assign at_swap    = (hcount == HC_W'(HSWAP));
    assign last_line  = (vcount == VC_W'(VTOTAL - 1));
    // Lines are rendered one ahead; the final blanking line pre-renders line 0.
    assign line_start = (hcount == '0) && enable && (state_reg == IDLE) &&
                        ((vcount <= VC_W'(VACTIVE - 2)) || last_line);
    assign frame_tick = (hcount == '0) && (vcount == VC_W'(VACTIVE));
    assign engine_done = (state_reg == TILE) ? eng.tile_done : eng.sprite_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            guard_reg        <= 1'b0;
            tile_start_reg   <= 1'b0;
            sprite_start_reg <= 1'b0;
            render_line_reg  <= '0;
            buf_sel_reg      <= 1'b0;
            abort_reg        <= 1'b0;
            overrun_cnt_reg  <= '0;
            overrun_flag_reg <= 1'b0;
            vblank_reg       <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            guard_reg        <= guard_next;
            tile_start_reg   <= tile_start_next;
            sprite_start_reg <= sprite_start_next;
            render_line_reg  <= render_line_next;
            buf_sel_reg      <= buf_sel_next;
            abort_reg        <= abort_next;
            overrun_cnt_reg  <= overrun_cnt_next;
            overrun_flag_reg <= overrun_flag_next;
            vblank_reg       <= vblank_next;
            frame_cnt_reg    <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        guard_next        = 1'b0;
        tile_start_next   = 1'b0;
        sprite_start_next = 1'b0;
        render_line_next  = render_line_reg;
        buf_sel_next      = buf_sel_reg;
        abort_next        = 1'b0;
        overrun_cnt_next  = overrun_cnt_reg;
        overrun_flag_next = clr_status ? 1'b0 : overrun_flag_reg;
        vblank_next       = clr_status ? 1'b0 : vblank_reg;
        frame_cnt_next    = frame_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (line_start) begin
                    state_next       = TILE;
                    guard_next       = 1'b1;
                    tile_start_next  = 1'b1;
                    render_line_next = last_line ? '0 : vcount + VC_W'(1);
                end
            end
            TILE, SPRITE: begin
                if (at_swap) begin
                    state_next        = IDLE;
                    abort_next        = 1'b1;
                    overrun_flag_next = 1'b1;
                    if (overrun_cnt_reg != 8'hFF) begin
                        overrun_cnt_next = overrun_cnt_reg + 8'd1;
                    end
                // guard_reg masks a done level left over from the previous job
                end else if (!guard_reg && engine_done) begin
                    if (state_reg == TILE) begin
                        state_next        = SPRITE;
                        guard_next        = 1'b1;
                        sprite_start_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (at_swap) begin
                    state_next   = IDLE;
                    buf_sel_next = ~buf_sel_reg;
                end
            end
            default: state_next = IDLE;
        endcase

        if (frame_tick) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
            vblank_next    = 1'b1;
        end
    end

    assign eng.tile_start   = tile_start_reg;
    assign eng.sprite_start = sprite_start_reg;
    assign eng.render_line  = render_line_reg;
    assign eng.buf_sel      = buf_sel_reg;
    assign line_abort       = abort_reg;
    assign vblank_irq       = vblank_reg;
    assign overrun_flag     = overrun_flag_reg;
    assign overrun_cnt      = overrun_cnt_reg;
    assign frame_cnt        = frame_cnt_reg;
    assign busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_render_sched.sv
// Scoreboard bench for render_sched: line stimulus pushes expected pulses, a monitor pops them.
module tb_render_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        enable = 1'b0;
    logic        clr_status = 1'b0;
    logic        line_abort, vblank_irq, overrun_flag, busy;
    logic [7:0]  overrun_cnt;
    logic [15:0] frame_cnt;

    render_sched_if eng_if ();

    render_sched dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .enable      (enable),
        .clr_status  (clr_status),
        .eng         (eng_if),
        .line_abort  (line_abort),
        .vblank_irq  (vblank_irq),
        .overrun_flag(overrun_flag),
        .overrun_cnt (overrun_cnt),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    localparam int NONE = 99999;

    typedef struct {
        int kind;   // 0 tile_start, 1 sprite_start, 2 line_abort
        int hc;
        int line;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_buf = 0, exp_cnt = 0, exp_flag = 0, exp_vblank = 0, exp_frame = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int k, input int h, input int l, input int c);
        ev_t e;
        e.kind = k; e.hc = h; e.line = l; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every start/abort pulse must match the next expected entry.
    task automatic take(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d at hc=%0d, required none", kind, hcount);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.hc != int'(hcount) || e.line != int'(eng_if.render_line) ||
                (kind == 2 && e.cnt != int'(overrun_cnt))) begin
                errors++;
                $display("FAIL event: got kind=%0d hc=%0d line=%0d cnt=%0d, required kind=%0d hc=%0d line=%0d cnt=%0d",
                         kind, hcount, eng_if.render_line, overrun_cnt, e.kind, e.hc, e.line, e.cnt);
            end else begin
                $display("event kind=%0d hc=%0d line=%0d cnt=%0d ok", kind, hcount, eng_if.render_line, overrun_cnt);
            end
        end
    endtask

    always @(negedge clk) begin
        if (eng_if.tile_start === 1'b1 && eng_if.sprite_start === 1'b1)
            chk("start_exclusive", 1, 0);
        if (eng_if.tile_start === 1'b1)   take(0);
        if (eng_if.sprite_start === 1'b1) take(1);
        if (line_abort === 1'b1)          take(2);
    end

    task automatic check_zero(input string tag);
        $display("reset check at %s", tag);
        chk("rst_tile_start",   int'(eng_if.tile_start), 0);
        chk("rst_sprite_start", int'(eng_if.sprite_start), 0);
        chk("rst_render_line",  int'(eng_if.render_line), 0);
        chk("rst_buf_sel",      int'(eng_if.buf_sel), 0);
        chk("rst_line_abort",   int'(line_abort), 0);
        chk("rst_vblank_irq",   int'(vblank_irq), 0);
        chk("rst_overrun_flag", int'(overrun_flag), 0);
        chk("rst_overrun_cnt",  int'(overrun_cnt), 0);
        chk("rst_frame_cnt",    int'(frame_cnt), 0);
        chk("rst_busy",         int'(busy), 0);
    endtask

    task automatic model_abort(input int rl, input int rst_at);
        if (rst_at > 1280) begin
            exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            exp_flag = 1;
            push_ev(2, 1281, rl, exp_cnt);
        end
    endtask

    // One scanline. Done levels are high at hc=0 (stale idle level), low until
    // their rise column. Fast lines visit only hc 0..15 and 1275..1285.
    task automatic run_line(input int v, input int trise, input int srise, input int en_until,
                            input bit fast, input int rst_at, input bit clr0);
        int rl, ts, ds;
        if (clr0) begin exp_vblank = 0; exp_flag = 0; end
        if (v == 480) begin exp_frame = (exp_frame + 1) % 65536; exp_vblank = 1; end
        if (en_until > 0 && (v <= 478 || v == 524)) begin
            rl = (v == 524) ? 0 : v + 1;
            push_ev(0, 1, rl, 0);
            ts = (trise > 2) ? trise : 2;
            if (ts < 1280) begin
                if (ts < rst_at) push_ev(1, ts + 1, rl, 0);
                ds = (srise > ts + 2) ? srise : ts + 2;
                if (ds < 1280) begin
                    if (rst_at > 1280) exp_buf ^= 1;
                end else begin
                    model_abort(rl, rst_at);
                end
            end else begin
                model_abort(rl, rst_at);
            end
        end
        if (rst_at < 1600) begin
            exp_buf = 0; exp_cnt = 0; exp_flag = 0; exp_vblank = 0; exp_frame = 0;
        end

        for (int hc = 0; hc < 1600; hc++) begin
            if (fast && hc == 16) hc = 1275;
            if (fast && hc > 1285) break;
            hcount             = 11'(hc);
            vcount             = 10'(v);
            enable             = (hc < en_until);
            eng_if.tile_done   = (hc == 0) || (hc >= trise);
            eng_if.sprite_done = (hc == 0) || (hc >= srise);
            clr_status         = clr0 && (hc == 0);
            reset              = (hc == rst_at);
            @(posedge clk);
            #1;
            if (hc == rst_at) check_zero("mid-render");
        end
        reset      = 1'b0;
        clr_status = 1'b0;

        chk("line_buf_sel",      int'(eng_if.buf_sel), exp_buf);
        chk("line_busy",         int'(busy), 0);
        chk("line_overrun_cnt",  int'(overrun_cnt), exp_cnt);
        chk("line_overrun_flag", int'(overrun_flag), exp_flag);
        chk("line_vblank_irq",   int'(vblank_irq), exp_vblank);
        chk("line_frame_cnt",    int'(frame_cnt), exp_frame);
    endtask

    initial begin
        // Reset must dominate a would-be line start.
        reset = 1'b1; enable = 1'b1; vcount = 10'd10; hcount = '0;
        eng_if.tile_done = 1'b1; eng_if.sprite_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("power-on");
        reset = 1'b0; enable = 1'b0; hcount = 11'd100;
        @(posedge clk);
        #1;

        run_line(10, 200, 900, 1600, 1'b0, NONE, 1'b0);    // nominal render, line 11
        run_line(524, 0, 0, 1600, 1'b0, NONE, 1'b0);       // wrap to line 0, done held high
        run_line(479, 0, 0, 1600, 1'b0, NONE, 1'b0);       // no start
        run_line(500, 0, 0, 1600, 1'b0, NONE, 1'b0);       // no start in blanking
        run_line(40, 300, 1000, 100, 1'b0, NONE, 1'b0);    // enable drops mid-render
        run_line(20, 200, 2000, 1600, 1'b0, NONE, 1'b0);   // sprite misses deadline
        for (int i = 0; i < 255; i++)
            run_line(i % 400, 2000, 2000, 1600, 1'b1, NONE, 1'b0);
        run_line(5, 0, 0, 0, 1'b1, NONE, 1'b1);            // clr_status only
        for (int v = 0; v < 525; v++)
            run_line(v, 0, 0, 1600, 1'b1, NONE, (v == 480));
        run_line(30, 200, 2000, 1600, 1'b0, 500, 1'b0);    // reset while in SPRITE
        run_line(31, 0, 0, 1600, 1'b0, NONE, 1'b0);        // recovers normally

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
